// File: rtl/mcd_pkg.sv
// Shared definitions for the MCD gate-array register blocks: register offsets and the INT2 state
// type.
package mcd_pkg;

  localparam logic [8:0] OFS_FLAGS    = 9'h00E;
  localparam logic [8:0] OFS_CMD0     = 9'h010;
  localparam logic [8:0] OFS_STAT0    = 9'h020;
  localparam logic [5:0] MAIN_OFS_INT = 6'h00;

  typedef enum logic [0:0] {
    INT2_IDLE = 1'b0,
    INT2_PEND = 1'b1
  } int2_st_t;

  // Word index of a byte offset inside a block of 16-bit words starting at base.
  function automatic logic [31:0] word_idx(input logic [31:0] ofs, input logic [31:0] base);
    return (ofs - base) >> 1;
  endfunction

endpackage

// File: rtl/mcd_comm_word.sv
// 16-bit communication word with independent byte-lane write strobes from its owning CPU.
// Updates on the falling clock edge, matching the rest of the gate array.
module mcd_comm_word (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] q_o
);

  logic [15:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (we_hi_i) word_d[15:8] = wdata_i[15:8];
    if (we_lo_i) word_d[7:0]  = wdata_i[7:0];
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/mcd_comm_regs.sv
// Main<->sub communication registers: COMFLAGS, COMCMD (main-owned), COMSTAT (sub-owned),
// registered read muxes for both CPUs and the INT2 request from main to sub.
module mcd_comm_regs
  import mcd_pkg::*;
#(
  parameter int unsigned N_CMD  = 8,
  parameter int unsigned N_STAT = 8
) (
  input  logic        clk_asic,
  input  logic        rst_n,
  input  logic [5:0]  main_addr,
  input  logic [15:0] main_data,
  input  logic        main_we_lo,
  input  logic        main_we_hi,
  output logic [15:0] main_dout,
  input  logic [14:0] regs_addr_sub,
  input  logic [15:0] sub_data,
  input  logic        regs_we_lo_sub,
  input  logic        regs_we_hi_sub,
  output logic [15:0] sub_dout,
  input  logic        ien2,
  input  logic        int2_ack,
  output logic        sub_int2,
  output logic        cmd_wr_evt
);

  localparam logic [31:0] FlagsOfs = 32'(OFS_FLAGS);
  localparam logic [31:0] IntOfs   = 32'(MAIN_OFS_INT);
  localparam logic [31:0] CmdLo    = 32'(OFS_CMD0);
  localparam logic [31:0] CmdHi    = CmdLo + 32'(2 * N_CMD);
  localparam logic [31:0] StatLo   = 32'(OFS_STAT0);
  localparam logic [31:0] StatHi   = StatLo + 32'(2 * N_STAT);

  // Both CPUs address 16-bit words; the byte-select bit plays no role here.
  logic [31:0] main_ofs, sub_ofs;
  logic        unused_addr_lsb;
  assign main_ofs        = {26'd0, main_addr[5:1], 1'b0};
  assign sub_ofs         = {17'd0, regs_addr_sub[14:1], 1'b0};
  assign unused_addr_lsb = main_addr[0] ^ regs_addr_sub[0];

  logic        main_any_we, sub_any_we;
  logic        main_flags_hit, main_cmd_hit, main_stat_hit, main_int_hit;
  logic        sub_flags_hit, sub_cmd_hit, sub_stat_hit;
  logic [31:0] main_cmd_idx, main_stat_idx, sub_cmd_idx, sub_stat_idx;

  assign main_any_we    = main_we_lo | main_we_hi;
  assign sub_any_we     = regs_we_lo_sub | regs_we_hi_sub;
  assign main_int_hit   = (main_ofs == IntOfs);
  assign main_flags_hit = (main_ofs == FlagsOfs);
  assign main_cmd_hit   = (main_ofs >= CmdLo) && (main_ofs < CmdHi);
  assign main_stat_hit  = (main_ofs >= StatLo) && (main_ofs < StatHi);
  assign sub_flags_hit  = (sub_ofs == FlagsOfs);
  assign sub_cmd_hit    = (sub_ofs >= CmdLo) && (sub_ofs < CmdHi);
  assign sub_stat_hit   = (sub_ofs >= StatLo) && (sub_ofs < StatHi);
  assign main_cmd_idx   = word_idx(main_ofs, CmdLo);
  assign main_stat_idx  = word_idx(main_ofs, StatLo);
  assign sub_cmd_idx    = word_idx(sub_ofs, CmdLo);
  assign sub_stat_idx   = word_idx(sub_ofs, StatLo);

  // COMCMD: written by main only; COMSTAT: written by sub only.
  logic [15:0] cmd_q  [N_CMD];
  logic [15:0] stat_q [N_STAT];

  for (genvar i = 0; i < N_CMD; i++) begin : g_cmd
    logic sel;
    assign sel = main_cmd_hit && (main_cmd_idx == 32'(i));
    mcd_comm_word u_word (
      .clk_i   (clk_asic),
      .rst_ni  (rst_n),
      .we_lo_i (sel & main_we_lo),
      .we_hi_i (sel & main_we_hi),
      .wdata_i (main_data),
      .q_o     (cmd_q[i])
    );
  end

  for (genvar i = 0; i < N_STAT; i++) begin : g_stat
    logic sel;
    assign sel = sub_stat_hit && (sub_stat_idx == 32'(i));
    mcd_comm_word u_word (
      .clk_i   (clk_asic),
      .rst_ni  (rst_n),
      .we_lo_i (sel & regs_we_lo_sub),
      .we_hi_i (sel & regs_we_hi_sub),
      .wdata_i (sub_data),
      .q_o     (stat_q[i])
    );
  end

  // COMFLAGS: each CPU owns one byte; a write on the "wrong" lane mirrors into the owned byte.
  logic [7:0] flags_hi_q, flags_hi_d, flags_lo_q, flags_lo_d;

  always_comb begin
    flags_hi_d = flags_hi_q;
    flags_lo_d = flags_lo_q;
    if (main_flags_hit) begin
      if (main_we_hi)      flags_hi_d = main_data[15:8];
      else if (main_we_lo) flags_hi_d = main_data[7:0];
    end
    if (sub_flags_hit) begin
      if (regs_we_lo_sub)      flags_lo_d = sub_data[7:0];
      else if (regs_we_hi_sub) flags_lo_d = sub_data[15:8];
    end
  end

  // INT2 request FSM.
  int2_st_t int2_q, int2_d;
  logic     int2_set;

  assign int2_set = main_we_lo && main_int_hit && main_data[0] && ien2;

  always_ff @(negedge clk_asic or negedge rst_n) begin
    if (!rst_n) begin
      int2_q <= INT2_IDLE;
    end else begin
      int2_q <= int2_d;
    end
  end

  always_comb begin
    int2_d = int2_q;
    unique case (int2_q)
      INT2_IDLE: if (int2_set) int2_d = INT2_PEND;
      INT2_PEND: begin
        if (int2_set)                int2_d = INT2_PEND;
        else if (int2_ack || !ien2)  int2_d = INT2_IDLE;
      end
    endcase
  end

  always_comb begin
    sub_int2 = (int2_q == INT2_PEND);
  end

  // Read muxes see pre-edge state, so a same-cycle write returns the old value.
  logic [15:0] main_rdata, sub_rdata;

  always_comb begin
    main_rdata = '0;
    if (main_int_hit) begin
      main_rdata = {15'd0, sub_int2};
    end else if (main_flags_hit) begin
      main_rdata = {flags_hi_q, flags_lo_q};
    end else if (main_cmd_hit) begin
      for (int i = 0; i < N_CMD; i++) begin
        if (main_cmd_idx == 32'(i)) main_rdata = cmd_q[i];
      end
    end else if (main_stat_hit) begin
      for (int i = 0; i < N_STAT; i++) begin
        if (main_stat_idx == 32'(i)) main_rdata = stat_q[i];
      end
    end
  end

  always_comb begin
    sub_rdata = '0;
    if (sub_flags_hit) begin
      sub_rdata = {flags_hi_q, flags_lo_q};
    end else if (sub_cmd_hit) begin
      for (int i = 0; i < N_CMD; i++) begin
        if (sub_cmd_idx == 32'(i)) sub_rdata = cmd_q[i];
      end
    end else if (sub_stat_hit) begin
      for (int i = 0; i < N_STAT; i++) begin
        if (sub_stat_idx == 32'(i)) sub_rdata = stat_q[i];
      end
    end
  end

  logic [15:0] main_dout_q, sub_dout_q;
  logic        cmd_wr_evt_q;

  always_ff @(negedge clk_asic or negedge rst_n) begin
    if (!rst_n) begin
      flags_hi_q   <= '0;
      flags_lo_q   <= '0;
      main_dout_q  <= '0;
      sub_dout_q   <= '0;
      cmd_wr_evt_q <= 1'b0;
    end else begin
      flags_hi_q   <= flags_hi_d;
      flags_lo_q   <= flags_lo_d;
      main_dout_q  <= main_rdata;
      sub_dout_q   <= sub_rdata;
      cmd_wr_evt_q <= main_cmd_hit && main_any_we;
    end
  end

  logic unused_sub_we;
  assign unused_sub_we = sub_any_we;

  assign main_dout  = main_dout_q;
  assign sub_dout   = sub_dout_q;
  assign cmd_wr_evt = cmd_wr_evt_q;

endmodule

// File: tb/tb_mcd_comm_regs.sv
// Directed bench for mcd_comm_regs: inputs change and outputs are sampled just after the rising
// edge, well away from the falling edge the design updates on.
module tb_mcd_comm_regs;

  logic        clk_asic = 1'b1;
  logic        rst_n    = 1'b1;
  logic [5:0]  main_addr = '0;
  logic [15:0] main_data = '0;
  logic        main_we_lo = 1'b0;
  logic        main_we_hi = 1'b0;
  logic [15:0] main_dout;
  logic [14:0] regs_addr_sub = '0;
  logic [15:0] sub_data = '0;
  logic        regs_we_lo_sub = 1'b0;
  logic        regs_we_hi_sub = 1'b0;
  logic [15:0] sub_dout;
  logic        ien2 = 1'b1;
  logic        int2_ack = 1'b0;
  logic        sub_int2;
  logic        cmd_wr_evt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_asic = ~clk_asic;

  mcd_comm_regs #(
    .N_CMD  (8),
    .N_STAT (8)
  ) u_dut (
    .clk_asic       (clk_asic),
    .rst_n          (rst_n),
    .main_addr      (main_addr),
    .main_data      (main_data),
    .main_we_lo     (main_we_lo),
    .main_we_hi     (main_we_hi),
    .main_dout      (main_dout),
    .regs_addr_sub  (regs_addr_sub),
    .sub_data       (sub_data),
    .regs_we_lo_sub (regs_we_lo_sub),
    .regs_we_hi_sub (regs_we_hi_sub),
    .sub_dout       (sub_dout),
    .ien2           (ien2),
    .int2_ack       (int2_ack),
    .sub_int2       (sub_int2),
    .cmd_wr_evt     (cmd_wr_evt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One falling edge for the design, then stop just after the next rising edge.
  task automatic cycle();
    @(negedge clk_asic);
    @(posedge clk_asic);
    #1;
  endtask

  task automatic main_wr(input logic [5:0] a, input logic [15:0] d, input logic lo, input logic hi);
    main_addr  = a;
    main_data  = d;
    main_we_lo = lo;
    main_we_hi = hi;
    cycle();
    main_we_lo = 1'b0;
    main_we_hi = 1'b0;
  endtask

  task automatic sub_wr(input logic [14:0] a, input logic [15:0] d, input logic lo, input logic hi);
    regs_addr_sub  = a;
    sub_data       = d;
    regs_we_lo_sub = lo;
    regs_we_hi_sub = hi;
    cycle();
    regs_we_lo_sub = 1'b0;
    regs_we_hi_sub = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_asic);
    #1 rst_n = 1'b1;
    check("reset_main_dout", main_dout, 16'h0000);
    check("reset_sub_dout", sub_dout, 16'h0000);
    check("reset_sub_int2", {15'd0, sub_int2}, 16'h0000);

    // COMCMD write from main, read from sub; sub writes ignored.
    main_wr(6'h12, 16'h1234, 1'b1, 1'b1);
    check("cmd_evt_pulse", {15'd0, cmd_wr_evt}, 16'h0001);
    regs_addr_sub = 15'h012;
    cycle();
    check("cmd_evt_once", {15'd0, cmd_wr_evt}, 16'h0000);
    check("cmd_sub_read", sub_dout, 16'h1234);
    sub_wr(15'h012, 16'hFFFF, 1'b1, 1'b1);
    check("cmd_sub_wr_no_evt", {15'd0, cmd_wr_evt}, 16'h0000);
    cycle();
    check("cmd_sub_wr_ignored", sub_dout, 16'h1234);
    main_addr = 6'h12;
    cycle();
    check("cmd_main_read", main_dout, 16'h1234);

    // COMFLAGS split ownership and byte mirrors.
    main_wr(6'h0E, 16'h00A5, 1'b1, 1'b0);
    cycle();
    check("flags_main_mirror", main_dout, 16'hA500);
    sub_wr(15'h00E, 16'h3C00, 1'b0, 1'b1);
    cycle();
    check("flags_main_view", main_dout, 16'hA53C);
    check("flags_sub_view", sub_dout, 16'hA53C);
    main_wr(6'h0E, 16'h66FF, 1'b1, 1'b1);
    cycle();
    check("flags_main_both_lanes", main_dout, 16'h663C);

    // COMSTAT byte lanes; main writes ignored.
    sub_wr(15'h02E, 16'hBEEF, 1'b1, 1'b1);
    sub_wr(15'h02E, 16'h0011, 1'b1, 1'b0);
    main_addr = 6'h2E;
    cycle();
    check("stat_lane_lo", main_dout, 16'hBE11);
    main_wr(6'h2E, 16'h0000, 1'b1, 1'b1);
    check("stat_main_wr_no_evt", {15'd0, cmd_wr_evt}, 16'h0000);
    cycle();
    check("stat_main_wr_ignored", main_dout, 16'hBE11);

    // INT2 request handling.
    ien2 = 1'b1;
    main_wr(6'h00, 16'h0001, 1'b1, 1'b0);
    check("int2_set", {15'd0, sub_int2}, 16'h0001);
    cycle();
    check("int2_main_read", main_dout, 16'h0001);
    int2_ack = 1'b1;
    cycle();
    int2_ack = 1'b0;
    check("int2_ack_clears", {15'd0, sub_int2}, 16'h0000);
    main_wr(6'h00, 16'h0001, 1'b1, 1'b0);
    int2_ack = 1'b1;
    main_wr(6'h00, 16'h0001, 1'b1, 1'b0);
    int2_ack = 1'b0;
    check("int2_set_beats_ack", {15'd0, sub_int2}, 16'h0001);
    ien2 = 1'b0;
    cycle();
    check("int2_ien2_drop", {15'd0, sub_int2}, 16'h0000);
    main_wr(6'h00, 16'h0001, 1'b1, 1'b0);
    check("int2_disabled_set", {15'd0, sub_int2}, 16'h0000);
    ien2 = 1'b1;
    main_wr(6'h00, 16'h0000, 1'b1, 1'b0);
    check("int2_bit0_clear", {15'd0, sub_int2}, 16'h0000);
    main_wr(6'h00, 16'h0001, 1'b0, 1'b1);
    check("int2_hi_strobe_only", {15'd0, sub_int2}, 16'h0000);

    // Read/write collision returns the old value first.
    main_wr(6'h14, 16'h1111, 1'b1, 1'b1);
    regs_addr_sub = 15'h014;
    main_wr(6'h14, 16'h5555, 1'b1, 1'b1);
    check("collision_old", sub_dout, 16'h1111);
    cycle();
    check("collision_new", sub_dout, 16'h5555);

    // Simultaneous main and sub writes to their own words.
    main_addr      = 6'h16;
    main_data      = 16'hAAAA;
    main_we_lo     = 1'b1;
    main_we_hi     = 1'b1;
    regs_addr_sub  = 15'h020;
    sub_data       = 16'hBBBB;
    regs_we_lo_sub = 1'b1;
    regs_we_hi_sub = 1'b1;
    cycle();
    main_we_lo = 1'b0; main_we_hi = 1'b0;
    regs_we_lo_sub = 1'b0; regs_we_hi_sub = 1'b0;
    main_addr     = 6'h20;
    regs_addr_sub = 15'h016;
    cycle();
    check("simul_main_sees_stat", main_dout, 16'hBBBB);
    check("simul_sub_sees_cmd", sub_dout, 16'hAAAA);

    // Unmapped offsets.
    main_addr     = 6'h30;
    regs_addr_sub = 15'h040;
    cycle();
    check("unmapped_main", main_dout, 16'h0000);
    check("unmapped_sub", sub_dout, 16'h0000);

    // Reset mid-operation with everything loaded.
    main_wr(6'h00, 16'h0001, 1'b1, 1'b0);
    main_addr     = 6'h12;
    regs_addr_sub = 15'h00E;
    cycle();
    check("preload_main", main_dout, 16'h1234);
    check("preload_sub", sub_dout, 16'h663C);
    rst_n = 1'b0;
    #2;
    check("midreset_main_dout", main_dout, 16'h0000);
    check("midreset_sub_dout", sub_dout, 16'h0000);
    check("midreset_sub_int2", {15'd0, sub_int2}, 16'h0000);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("postreset_cmd", main_dout, 16'h0000);
    check("postreset_flags", sub_dout, 16'h0000);
    main_wr(6'h12, 16'h4321, 1'b1, 1'b1);
    cycle();
    check("postreset_first_write", main_dout, 16'h4321);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
